mvm_uart_link: RTL and testbench

MVM_UART_LINK -- requirements
Module: mvm_uart_link

---
 rtl/mvm_uart_link.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mvm_uart_link.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_uart_link.sv
// mvm_uart_link: UART byte-stream framing front-end for a matrix-vector-multiply core.
// Receives A5-framed requests (K and/or X operands), issues them over an AXIS-style
// port, waits for the Y result and returns a 5A-framed response with status and checksum.
module mvm_uart_link #(
    parameter int unsigned R            = 8,
    parameter int unsigned C            = 8,
    parameter int unsigned W_X          = 8,
    parameter int unsigned W_K          = 8,
    parameter int unsigned TIMEOUT_CLKS = 200_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_byte_valid,
    input  logic [7:0]                        s_byte_data,
    output logic                              m_byte_valid,
    output logic [7:0]                        m_byte_data,
    input  logic                              m_byte_ready,
    output logic                              m_axis_kx_tvalid,
    output logic [R*C*W_K+C*W_X-1:0]          m_axis_kx_tdata,
    input  logic                              m_axis_kx_tready,
    input  logic                              s_axis_y_tvalid,
    input  logic [R*(W_X+W_K+$clog2(C))-1:0]  s_axis_y_tdata,
    output logic                              s_axis_y_tready,
    output logic                              k_loaded,
    output logic                              frame_err
);

    localparam int unsigned W_Y      = W_X + W_K + $clog2(C);
    localparam int unsigned KW       = R * C * W_K;
    localparam int unsigned XW       = C * W_X;
    localparam int unsigned YW       = R * W_Y;
    localparam int unsigned N_K      = KW / 8;
    localparam int unsigned N_X      = XW / 8;
    localparam int unsigned N_Y      = (YW + 7) / 8;
    localparam int unsigned YPW      = 8 * N_Y;
    localparam int unsigned N_KX_MAX = (N_K > N_X) ? N_K : N_X;
    localparam int unsigned N_MAX    = (N_KX_MAX > N_Y) ? N_KX_MAX : N_Y;
    localparam int unsigned CNT_W    = $clog2(N_MAX + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [7:0] SOF_REQ   = 8'hA5;
    localparam logic [7:0] SOF_RSP   = 8'h5A;
    localparam logic [7:0] CMD_KX    = 8'h01;
    localparam logic [7:0] CMD_X     = 8'h02;
    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_CHK    = 8'h01;
    localparam logic [7:0] ST_BADCMD = 8'h02;
    localparam logic [7:0] ST_NOK    = 8'h03;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_RX_K, S_RX_X, S_CHECK, S_ISSUE,
        S_WAIT_Y, S_TX_HDR, S_TX_STAT, S_TX_DATA, S_TX_CHK
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [TO_W-1:0]  r_to_cnt, w_to_nxt;
    logic [7:0]       r_cmd, w_cmd_nxt;
    logic [7:0]       r_rx_chk, w_rx_chk_nxt;
    logic [KW-1:0]    r_k_shadow, w_k_shadow_nxt;
    logic [KW-1:0]    r_k_active, w_k_active_nxt;
    logic [XW-1:0]    r_x, w_x_nxt;
    logic [YPW-1:0]   r_y, w_y_nxt;
    logic [7:0]       r_status, w_status_nxt;
    logic [7:0]       r_tx_chk, w_tx_chk_nxt;
    logic             r_k_loaded, w_k_loaded_nxt;
    logic             r_frame_err, w_frame_err_nxt;
    logic             r_m_byte_valid, w_byte_valid_nxt;
    logic [7:0]       r_m_byte_data, w_byte_data_nxt;
    logic             r_kx_tvalid;
    logic             r_y_tready;

    logic [YPW-1:0]   w_y_pad;
    logic [YPW-1:0]   w_y_sh;
    logic [7:0]       w_y_xor;
    logic             w_in_rx;
    logic             w_in_busy;
    logic             w_tx_hs;

    assign m_byte_valid     = r_m_byte_valid;
    assign m_byte_data      = r_m_byte_data;
    assign m_axis_kx_tvalid = r_kx_tvalid;
    assign m_axis_kx_tdata  = {r_x, r_k_active};
    assign s_axis_y_tready  = r_y_tready;
    assign k_loaded         = r_k_loaded;
    assign frame_err        = r_frame_err;

    // State and datapath registers; outputs are loaded from their next-cycle values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_to_cnt       <= '0;
            r_cmd          <= '0;
            r_rx_chk       <= '0;
            r_k_shadow     <= '0;
            r_k_active     <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_status       <= '0;
            r_tx_chk       <= '0;
            r_k_loaded     <= 1'b0;
            r_frame_err    <= 1'b0;
            r_m_byte_valid <= 1'b0;
            r_m_byte_data  <= '0;
            r_kx_tvalid    <= 1'b0;
            r_y_tready     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_to_cnt       <= w_to_nxt;
            r_cmd          <= w_cmd_nxt;
            r_rx_chk       <= w_rx_chk_nxt;
            r_k_shadow     <= w_k_shadow_nxt;
            r_k_active     <= w_k_active_nxt;
            r_x            <= w_x_nxt;
            r_y            <= w_y_nxt;
            r_status       <= w_status_nxt;
            r_tx_chk       <= w_tx_chk_nxt;
            r_k_loaded     <= w_k_loaded_nxt;
            r_frame_err    <= w_frame_err_nxt;
            r_m_byte_valid <= w_byte_valid_nxt;
            r_m_byte_data  <= w_byte_data_nxt;
            r_kx_tvalid    <= (w_state_nxt == S_ISSUE);
            r_y_tready     <= (w_state_nxt == S_WAIT_Y);
        end
    end

    // Next-state, datapath updates, timeout and overrun detection
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_to_nxt        = '0;
        w_cmd_nxt       = r_cmd;
        w_rx_chk_nxt    = r_rx_chk;
        w_k_shadow_nxt  = r_k_shadow;
        w_k_active_nxt  = r_k_active;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_status_nxt    = r_status;
        w_tx_chk_nxt    = r_tx_chk;
        w_k_loaded_nxt  = r_k_loaded;
        w_frame_err_nxt = 1'b0;

        w_y_pad = YPW'(s_axis_y_tdata);
        w_y_xor = '0;
        for (int unsigned i = 0; i < N_Y; i++) begin
            w_y_xor = w_y_xor ^ 8'(w_y_pad >> (i * 32'd8));
        end

        w_in_rx   = (r_state == S_CMD) || (r_state == S_RX_K) ||
                    (r_state == S_RX_X) || (r_state == S_CHECK);
        w_in_busy = (r_state == S_ISSUE) || (r_state == S_WAIT_Y) ||
                    (r_state == S_TX_HDR) || (r_state == S_TX_STAT) ||
                    (r_state == S_TX_DATA) || (r_state == S_TX_CHK);
        w_tx_hs   = r_m_byte_valid && m_byte_ready;

        case (r_state)
            S_IDLE: begin
                if (s_byte_valid && (s_byte_data == SOF_REQ)) w_state_nxt = S_CMD;
            end
            S_CMD: begin
                if (s_byte_valid) begin
                    w_cmd_nxt    = s_byte_data;
                    w_rx_chk_nxt = s_byte_data;
                    if (s_byte_data == CMD_KX) begin
                        w_state_nxt = S_RX_K;
                    end else if (s_byte_data == CMD_X && r_k_loaded) begin
                        w_state_nxt = S_RX_X;
                    end else if (s_byte_data == CMD_X) begin
                        w_status_nxt = ST_NOK;
                        w_tx_chk_nxt = ST_NOK;
                        w_state_nxt  = S_TX_HDR;
                    end else begin
                        w_status_nxt    = ST_BADCMD;
                        w_tx_chk_nxt    = ST_BADCMD;
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_TX_HDR;
                    end
                end
            end
            S_RX_K: begin
                if (s_byte_valid) begin
                    w_k_shadow_nxt = (r_k_shadow >> 8) | (KW'(s_byte_data) << (KW - 8));
                    w_rx_chk_nxt   = r_rx_chk ^ s_byte_data;
                    if (r_cnt == CNT_W'(N_K - 1)) w_state_nxt = S_RX_X;
                    else                          w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_RX_X: begin
                if (s_byte_valid) begin
                    w_x_nxt      = (r_x >> 8) | (XW'(s_byte_data) << (XW - 8));
                    w_rx_chk_nxt = r_rx_chk ^ s_byte_data;
                    if (r_cnt == CNT_W'(N_X - 1)) w_state_nxt = S_CHECK;
                    else                          w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (s_byte_valid) begin
                    if (s_byte_data == r_rx_chk) begin
                        if (r_cmd == CMD_KX) begin
                            w_k_active_nxt = r_k_shadow;
                            w_k_loaded_nxt = 1'b1;
                        end
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_status_nxt    = ST_CHK;
                        w_tx_chk_nxt    = ST_CHK;
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_TX_HDR;
                    end
                end
            end
            S_ISSUE: begin
                if (r_kx_tvalid && m_axis_kx_tready) w_state_nxt = S_WAIT_Y;
            end
            S_WAIT_Y: begin
                if (r_y_tready && s_axis_y_tvalid) begin
                    w_y_nxt      = w_y_pad;
                    w_status_nxt = ST_OK;
                    w_tx_chk_nxt = w_y_xor;
                    w_state_nxt  = S_TX_HDR;
                end
            end
            S_TX_HDR: begin
                if (w_tx_hs) w_state_nxt = S_TX_STAT;
            end
            S_TX_STAT: begin
                if (w_tx_hs) w_state_nxt = (r_status == ST_OK) ? S_TX_DATA : S_TX_CHK;
            end
            S_TX_DATA: begin
                if (w_tx_hs) begin
                    if (r_cnt == CNT_W'(N_Y - 1)) w_state_nxt = S_TX_CHK;
                    else                          w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_TX_CHK: begin
                if (w_tx_hs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Idle-gap watchdog while a request frame is partially received
        if (w_in_rx && !s_byte_valid) begin
            if (r_to_cnt == TO_W'(TIMEOUT_CLKS)) begin
                w_state_nxt     = S_IDLE;
                w_frame_err_nxt = 1'b1;
            end else begin
                w_to_nxt = r_to_cnt + TO_W'(1);
            end
        end

        // Bytes cannot be stalled, so any arriving while busy are lost
        if (s_byte_valid && w_in_busy) w_frame_err_nxt = 1'b1;

        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    // Response byte to present in the next cycle, from next-state values
    always_comb begin
        w_byte_valid_nxt = 1'b0;
        w_byte_data_nxt  = '0;
        w_y_sh           = w_y_nxt >> (32'(w_cnt_nxt) * 32'd8);
        case (w_state_nxt)
            S_TX_HDR:  begin w_byte_valid_nxt = 1'b1; w_byte_data_nxt = SOF_RSP;      end
            S_TX_STAT: begin w_byte_valid_nxt = 1'b1; w_byte_data_nxt = w_status_nxt; end
            S_TX_DATA: begin w_byte_valid_nxt = 1'b1; w_byte_data_nxt = w_y_sh[7:0];  end
            S_TX_CHK:  begin w_byte_valid_nxt = 1'b1; w_byte_data_nxt = w_tx_chk_nxt; end
            default:   begin w_byte_valid_nxt = 1'b0; w_byte_data_nxt = '0;           end
        endcase
    end

endmodule

// File: tb/tb_mvm_uart_link.sv
// tb_mvm_uart_link: scoreboard bench for mvm_uart_link with R=C=2, 8-bit elements.
// Expected response bytes and operand words are queued when frames are sent and
// popped by the tx monitor and the core model when the DUT produces them.
module tb_mvm_uart_link;

    localparam int unsigned R     = 2;
    localparam int unsigned C     = 2;
    localparam int unsigned TO    = 64;
    localparam int unsigned KXW   = 48;
    localparam int unsigned YW    = 34;
    localparam int unsigned N_Y   = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_byte_valid;
    logic [7:0]     s_byte_data;
    logic           m_byte_valid;
    logic [7:0]     m_byte_data;
    logic           m_byte_ready;
    logic           m_axis_kx_tvalid;
    logic [KXW-1:0] m_axis_kx_tdata;
    logic           m_axis_kx_tready;
    logic           s_axis_y_tvalid;
    logic [YW-1:0]  s_axis_y_tdata;
    logic           s_axis_y_tready;
    logic           k_loaded;
    logic           frame_err;

    logic [7:0]     exp_tx[$];
    logic [KXW-1:0] exp_kx[$];
    logic [YW-1:0]  y_q[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    int             ferr_cnt = 0;

    mvm_uart_link #(.R(R), .C(C), .W_X(8), .W_K(8), .TIMEOUT_CLKS(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .s_byte_valid     (s_byte_valid),
        .s_byte_data      (s_byte_data),
        .m_byte_valid     (m_byte_valid),
        .m_byte_data      (m_byte_data),
        .m_byte_ready     (m_byte_ready),
        .m_axis_kx_tvalid (m_axis_kx_tvalid),
        .m_axis_kx_tdata  (m_axis_kx_tdata),
        .m_axis_kx_tready (m_axis_kx_tready),
        .s_axis_y_tvalid  (s_axis_y_tvalid),
        .s_axis_y_tdata   (s_axis_y_tdata),
        .s_axis_y_tready  (s_axis_y_tready),
        .k_loaded         (k_loaded),
        .frame_err        (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response byte monitor; an unexpected byte meets an unreachable expectation
    always @(negedge clk) begin
        logic [63:0] e;
        if (m_byte_valid && m_byte_ready) begin
            e = (exp_tx.size() != 0) ? 64'(exp_tx.pop_front()) : 64'h100;
            check("tx_byte", 64'(m_byte_data), e);
        end
    end

    // Count frame_err pulses
    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
    end

    // MVM core model: accept operands after a random delay, then return a queued Y
    initial begin : core_model
        logic [63:0]   e;
        logic [YW-1:0] y;
        int            k;
        m_axis_kx_tready = 1'b0;
        s_axis_y_tvalid  = 1'b0;
        s_axis_y_tdata   = '0;
        forever begin
            @(posedge clk); #1;
            if (m_axis_kx_tvalid && !rst) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                check("kx_tvalid_hold", 64'(m_axis_kx_tvalid), 64'd1);
                e = (exp_kx.size() != 0) ? 64'(exp_kx.pop_front()) : 64'h1_0000_0000_0000;
                check("kx_tdata", 64'(m_axis_kx_tdata), e);
                m_axis_kx_tready = 1'b1;
                @(posedge clk); #1;
                m_axis_kx_tready = 1'b0;
                y = (y_q.size() != 0) ? y_q.pop_front() : '0;
                repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                s_axis_y_tvalid = 1'b1;
                s_axis_y_tdata  = y;
                k = 0;
                while (!s_axis_y_tready && k < 200) begin @(posedge clk); #1; k++; end
                @(posedge clk); #1;
                s_axis_y_tvalid = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        s_byte_valid = 1'b1;
        s_byte_data  = b;
        @(posedge clk); #1;
        s_byte_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [63:0] pl, input int n,
                              input bit bad_chk);
        logic [7:0] chk;
        logic [7:0] b;
        chk = cmd;
        send_byte(8'hA5);
        send_byte(cmd);
        for (int i = 0; i < n; i++) begin
            b   = 8'(pl >> (8 * i));
            chk = chk ^ b;
            send_byte(b);
        end
        if (bad_chk) chk = ~chk;
        send_byte(chk);
    endtask

    task automatic push_resp(input logic [7:0] status, input logic [YW-1:0] y);
        logic [7:0] chk;
        logic [7:0] b;
        chk = status;
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(status);
        if (status == 8'h00) begin
            for (int i = 0; i < N_Y; i++) begin
                b   = 8'(y >> (8 * i));
                chk = chk ^ b;
                exp_tx.push_back(b);
            end
        end
        exp_tx.push_back(chk);
    endtask

    task automatic push_op(input logic [KXW-1:0] kx, input logic [YW-1:0] y);
        exp_kx.push_back(kx);
        y_q.push_back(y);
        push_resp(8'h00, y);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_tx.size() != 0 || exp_kx.size() != 0) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, 64'(exp_tx.size() + exp_kx.size()), 64'd0);
        repeat (5) begin @(posedge clk); #1; end
    endtask

    initial begin : stimulus
        int            f0;
        int            unstable;
        int            k;
        logic [7:0]    held;
        logic [YW-1:0] yr;

        rst          = 1'b1;
        s_byte_valid = 1'b0;
        s_byte_data  = '0;
        m_byte_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_m_byte_valid", 64'(m_byte_valid), 64'd0);
        check("rst_kx_tvalid", 64'(m_axis_kx_tvalid), 64'd0);
        check("rst_y_tready", 64'(s_axis_y_tready), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_k_loaded", 64'(k_loaded), 64'd0);
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Status-only responses: no K held, then an unknown command
        push_resp(8'h03, '0);
        send_byte(8'h33);
        send_byte(8'hA5);
        send_byte(8'h02);
        drain("drain_nok");
        f0 = ferr_cnt;
        push_resp(8'h02, '0);
        send_byte(8'hA5);
        send_byte(8'h7F);
        drain("drain_badcmd");
        check("badcmd_ferr", 64'(ferr_cnt - f0), 64'd1);

        // Full K+X load
        push_op(48'h0605_0403_0201, 34'h0_0000_001B);
        send_frame(8'h01, 64'h0605_0403_0201, 6, 1'b0);
        drain("drain_kx");
        check("k_loaded_set", 64'(k_loaded), 64'd1);

        // X only, reusing stored K
        push_op(48'h0807_0403_0201, 34'h2_DEAD_BEEF);
        send_frame(8'h02, 64'h0807, 2, 1'b0);
        drain("drain_x");

        // Bad checksum keeps the active K
        f0 = ferr_cnt;
        push_resp(8'h01, '0);
        send_frame(8'h01, 64'h6655_4433_2211, 6, 1'b1);
        drain("drain_badchk");
        check("badchk_ferr", 64'(ferr_cnt - f0), 64'd1);
        check("badchk_k_loaded", 64'(k_loaded), 64'd1);
        push_op(48'h0A09_0403_0201, 34'h0);
        send_frame(8'h02, 64'h0A09, 2, 1'b0);
        drain("drain_after_badchk");

        // Inter-byte timeout, then normal operation resumes
        f0 = ferr_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        repeat (TO + 10) begin @(posedge clk); #1; end
        check("timeout_ferr", 64'(ferr_cnt - f0), 64'd1);
        check("timeout_no_tx", 64'(m_byte_valid), 64'd0);
        yr = YW'({$urandom, $urandom});
        push_op(48'h3344_0403_0201, yr);
        send_frame(8'h02, 64'h3344, 2, 1'b0);
        drain("drain_after_timeout");

        // Backpressure mid-response with an overrun byte
        push_op(48'h5566_0403_0201, 34'h3_1234_5678);
        send_frame(8'h02, 64'h5566, 2, 1'b0);
        k = 0;
        while (!(m_byte_valid && exp_tx.size() <= 4) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        check("stall_reach", 64'(m_byte_valid), 64'd1);
        m_byte_ready = 1'b0;
        held         = m_byte_data;
        f0           = ferr_cnt;
        unstable     = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin s_byte_valid = 1'b1; s_byte_data = 8'hEE; end
            if (i == 11) s_byte_valid = 1'b0;
            if (!m_byte_valid || m_byte_data !== held) unstable++;
            @(posedge clk); #1;
        end
        check("stall_stable", 64'(unstable), 64'd0);
        check("overrun_ferr", 64'(ferr_cnt - f0), 64'd1);
        m_byte_ready = 1'b1;
        drain("drain_stall");

        // Reset during a held response emits nothing further and clears K
        m_byte_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h7F);
        repeat (3) begin @(posedge clk); #1; end
        check("pre_rst_valid", 64'(m_byte_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", 64'(m_byte_valid), 64'd0);
        rst          = 1'b0;
        m_byte_ready = 1'b1;
        check("post_rst_k_loaded", 64'(k_loaded), 64'd0);
        repeat (20) begin @(posedge clk); #1; end

        // Reset mid-frame, then the link starts fresh
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_resp(8'h03, '0);
        send_byte(8'hA5);
        send_byte(8'h02);
        drain("drain_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
